datacache_control: RTL and testbench



---
 rtl/dcache_ctrl_pkg.sv | 38 +++
 rtl/sat_counter.sv | 23 ++
 rtl/datacache_control.sv | 139 +++++++++++++
 tb/tb_datacache_control.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_ctrl_pkg.sv
// Shared types for the L1 data-cache controller: FSM states, datapath mode
// encodings and the bundle of control outputs the FSM drives each cycle.
package dcache_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        WB,
        FILL,
        SETTLE,
        COMMIT
    } state_t;

    localparam logic [2:0] ST_IDLE      = 3'b000;
    localparam logic [2:0] ST_CPU_WR    = 3'b100;
    localparam logic [2:0] ST_WB        = 3'b001;
    localparam logic [2:0] ST_FILL_ADDR = 3'b011;
    localparam logic [2:0] ST_FILL_WR   = 3'b111;

    typedef struct packed {
        logic       mem_resp;
        logic       pmem_read;
        logic       pmem_write;
        logic [1:0] ld_tag;
        logic [1:0] ld_valid;
        logic [1:0] ld_dirty;
        logic       valid_in;
        logic       dirty_in_value;
        logic       lru_in_value;
        logic       ld_lru;
        logic [2:0] status;
    } ctrl_t;

    function automatic ctrl_t ctrl_defaults();
        return '0;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Performance counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] count
);

    localparam logic [CNT_WIDTH-1:0] ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/datacache_control.sv
// Sequencing FSM for the 2-way, 8-set L1 data cache: hit check, dirty-victim
// writeback, line fill and saturating hit/miss/writeback counters.
module datacache_control
    import dcache_ctrl_pkg::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mem_read,
    input  logic                 mem_write,
    output logic                 mem_resp,
    input  logic                 HIT,
    input  logic                 way_hit,
    input  logic                 lru_data,
    input  logic [1:0]           valid_out,
    input  logic [1:0]           dirty_out,
    output logic                 pmem_read,
    output logic                 pmem_write,
    input  logic                 pmem_resp,
    output logic [1:0]           LD_TAG,
    output logic [1:0]           LD_VALID,
    output logic [1:0]           LD_DIRTY_in,
    output logic                 valid_in,
    output logic                 dirty_in_value,
    output logic                 lru_in_value,
    output logic                 LD_LRU_in,
    output logic [2:0]           W_CACHE_STATUS,
    output logic [CNT_WIDTH-1:0] hit_cnt,
    output logic [CNT_WIDTH-1:0] miss_cnt,
    output logic [CNT_WIDTH-1:0] wb_cnt
);

    state_t state, next_state;
    logic   victim;
    ctrl_t  ctrl;
    logic   hit_inc, miss_inc, wb_inc;
    logic   req;

    assign req = mem_read | mem_write;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            victim <= 1'b0;
        end else begin
            state <= next_state;
            // Victim way is frozen here; LRU stays untouched until the re-check hit.
            if (state == CHECK && req && !HIT) begin
                victim <= lru_data;
            end
        end
    end

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the case statement can infer a latch.
        ctrl       = ctrl_defaults();
        next_state = state;
        hit_inc    = 1'b0;
        miss_inc   = 1'b0;
        wb_inc     = 1'b0;
        case (state)
            IDLE: begin
                if (req) next_state = CHECK;
            end
            CHECK: begin
                if (!req) begin
                    next_state = IDLE;
                end else if (HIT) begin
                    hit_inc           = 1'b1;
                    ctrl.mem_resp     = 1'b1;
                    ctrl.ld_lru       = 1'b1;
                    ctrl.lru_in_value = ~way_hit;
                    if (mem_write) begin
                        ctrl.status             = ST_CPU_WR;
                        ctrl.ld_dirty[way_hit]  = 1'b1;
                        ctrl.dirty_in_value     = 1'b1;
                        next_state              = COMMIT;
                    end else begin
                        next_state = IDLE;
                    end
                end else begin
                    miss_inc = 1'b1;
                    if (valid_out[lru_data] && dirty_out[lru_data]) begin
                        wb_inc     = 1'b1;
                        next_state = WB;
                    end else begin
                        next_state = FILL;
                    end
                end
            end
            WB: begin
                ctrl.status     = ST_WB;
                ctrl.pmem_write = 1'b1;
                if (pmem_resp) next_state = FILL;
            end
            FILL: begin
                ctrl.status    = ST_FILL_ADDR;
                ctrl.pmem_read = 1'b1;
                if (pmem_resp) begin
                    ctrl.status           = ST_FILL_WR;
                    ctrl.ld_tag[victim]   = 1'b1;
                    ctrl.ld_valid[victim] = 1'b1;
                    ctrl.valid_in         = 1'b1;
                    ctrl.ld_dirty[victim] = 1'b1;
                    ctrl.dirty_in_value   = 1'b0;
                    next_state            = SETTLE;
                end
            end
            SETTLE: next_state = CHECK;
            COMMIT: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign mem_resp       = ctrl.mem_resp;
    assign pmem_read      = ctrl.pmem_read;
    assign pmem_write     = ctrl.pmem_write;
    assign LD_TAG         = ctrl.ld_tag;
    assign LD_VALID       = ctrl.ld_valid;
    assign LD_DIRTY_in    = ctrl.ld_dirty;
    assign valid_in       = ctrl.valid_in;
    assign dirty_in_value = ctrl.dirty_in_value;
    assign lru_in_value   = ctrl.lru_in_value;
    assign LD_LRU_in      = ctrl.ld_lru;
    assign W_CACHE_STATUS = ctrl.status;

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_hit_cnt (
        .clk(clk), .rst(rst), .inc(hit_inc), .count(hit_cnt)
    );
    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_miss_cnt (
        .clk(clk), .rst(rst), .inc(miss_inc), .count(miss_cnt)
    );
    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_wb_cnt (
        .clk(clk), .rst(rst), .inc(wb_inc), .count(wb_cnt)
    );

endmodule

// File: tb/tb_datacache_control.sv
// Bench for datacache_control: a stand-in datapath with the one-cycle update
// pipeline, plus a transaction-level cache model that predicts each output cycle.
module tb_datacache_control;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read, mem_write, pmem_resp;
    logic        HIT, way_hit, lru_data;
    logic [1:0]  valid_out, dirty_out;
    logic        mem_resp, pmem_read, pmem_write;
    logic [1:0]  LD_TAG, LD_VALID, LD_DIRTY_in;
    logic        valid_in, dirty_in_value, lru_in_value, LD_LRU_in;
    logic [2:0]  W_CACHE_STATUS;
    logic [31:0] hit_cnt, miss_cnt, wb_cnt;
    logic [31:0] addr;

    logic        s_mem_resp, s_pmem_read, s_pmem_write;
    logic [1:0]  s_ld_tag, s_ld_valid, s_ld_dirty;
    logic        s_valid_in, s_dirty_in_value, s_lru_in_value, s_ld_lru;
    logic [2:0]  s_status;
    logic [3:0]  s_hit_cnt, s_miss_cnt, s_wb_cnt;

    always #5 clk = ~clk;

    datacache_control #(.CNT_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .mem_resp(mem_resp), .HIT(HIT), .way_hit(way_hit), .lru_data(lru_data),
        .valid_out(valid_out), .dirty_out(dirty_out), .pmem_read(pmem_read),
        .pmem_write(pmem_write), .pmem_resp(pmem_resp), .LD_TAG(LD_TAG),
        .LD_VALID(LD_VALID), .LD_DIRTY_in(LD_DIRTY_in), .valid_in(valid_in),
        .dirty_in_value(dirty_in_value), .lru_in_value(lru_in_value),
        .LD_LRU_in(LD_LRU_in), .W_CACHE_STATUS(W_CACHE_STATUS),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .wb_cnt(wb_cnt)
    );

    datacache_control #(.CNT_WIDTH(4)) dut_small (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .mem_resp(s_mem_resp), .HIT(HIT), .way_hit(way_hit), .lru_data(lru_data),
        .valid_out(valid_out), .dirty_out(dirty_out), .pmem_read(s_pmem_read),
        .pmem_write(s_pmem_write), .pmem_resp(pmem_resp), .LD_TAG(s_ld_tag),
        .LD_VALID(s_ld_valid), .LD_DIRTY_in(s_ld_dirty), .valid_in(s_valid_in),
        .dirty_in_value(s_dirty_in_value), .lru_in_value(s_lru_in_value),
        .LD_LRU_in(s_ld_lru), .W_CACHE_STATUS(s_status),
        .hit_cnt(s_hit_cnt), .miss_cnt(s_miss_cnt), .wb_cnt(s_wb_cnt)
    );

    // ---------------- stand-in datapath arrays ----------------
    bit [23:0] e_tag   [8][2];
    bit        e_valid [8][2];
    bit        e_dirty [8][2];
    bit        e_lru   [8];
    logic [2:0]  lk_set;
    logic [23:0] lk_tag;
    logic        h0, h1;

    always_comb begin
        lk_set    = addr[7:5];
        lk_tag    = addr[31:8];
        h0        = e_valid[lk_set][0] && (e_tag[lk_set][0] == lk_tag);
        h1        = e_valid[lk_set][1] && (e_tag[lk_set][1] == lk_tag);
        HIT       = h0 | h1;
        way_hit   = h1;
        lru_data  = e_lru[lk_set];
        valid_out = {e_valid[lk_set][1], e_valid[lk_set][0]};
        dirty_out = {e_dirty[lk_set][1], e_dirty[lk_set][0]};
    end

    typedef struct packed {
        logic [1:0]  ld_tag, ld_valid, ld_dirty;
        logic        vin, dval, ld_lru, lru_val;
        logic [2:0]  set;
        logic [23:0] tag;
    } pend_t;
    pend_t s1 = '0;
    pend_t s2 = '0;

    // Loads commanded in cycle n land just after the edge closing cycle n+1.
    always @(negedge clk) begin
        s1.ld_tag   = LD_TAG;
        s1.ld_valid = LD_VALID;
        s1.ld_dirty = LD_DIRTY_in;
        s1.vin      = valid_in;
        s1.dval     = dirty_in_value;
        s1.ld_lru   = LD_LRU_in;
        s1.lru_val  = lru_in_value;
        s1.set      = addr[7:5];
        s1.tag      = addr[31:8];
    end

    always @(posedge clk) begin
        #1;
        for (int i = 0; i < 2; i++) begin
            if (s2.ld_tag[i])   e_tag[s2.set][i]   = s2.tag;
            if (s2.ld_valid[i]) e_valid[s2.set][i] = s2.vin;
            if (s2.ld_dirty[i]) e_dirty[s2.set][i] = s2.dval;
        end
        if (s2.ld_lru) e_lru[s2.set] = s2.lru_val;
        s2 = s1;
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [15:0] mk(bit mr, bit pr, bit pw, logic [2:0] st, logic [1:0] lt,
                                       logic [1:0] lv, logic [1:0] ld, bit vin, bit dv, bit lval, bit ll);
        return {mr, pr, pw, st, lt, lv, ld, vin, dv, lval, ll};
    endfunction

    function automatic logic [15:0] mk_hit(bit w, bit wr);
        logic [1:0] oh;
        oh = w ? 2'b10 : 2'b01;
        return mk(1, 0, 0, wr ? 3'b100 : 3'b000, 2'b00, 2'b00, wr ? oh : 2'b00, 0, wr, !w, 1);
    endfunction

    function automatic logic [15:0] mk_fw(bit v);
        logic [1:0] oh;
        oh = v ? 2'b10 : 2'b01;
        return mk(0, 1, 0, 3'b111, oh, oh, oh, 1, 0, 0, 0);
    endfunction

    localparam logic [15:0] E_WB = 16'b0_0_1_001_00_00_00_0000;
    localparam logic [15:0] E_FA = 16'b0_1_0_011_00_00_00_0000;

    logic [15:0] exp_q[$];
    logic [15:0] act_v, exp_v;
    bit          chk_en = 0;
    int          resp_at = 0;
    logic [1:0]  last_ld_tag = 2'b00;
    bit          last_lru_val = 0;
    int          pw_cycles = 0;
    int          both_hi = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            act_v = {mem_resp, pmem_read, pmem_write, W_CACHE_STATUS, LD_TAG, LD_VALID,
                     LD_DIRTY_in, valid_in, dirty_in_value, lru_in_value, LD_LRU_in};
            if (exp_q.size() > 0) exp_v = exp_q.pop_front();
            else exp_v = 16'h0;
            check($sformatf("outputs@cyc%0d", cyc), {16'h0, act_v}, {16'h0, exp_v});
            if (mem_resp) resp_at = cyc;
            if (LD_TAG != 2'b00) last_ld_tag = LD_TAG;
            if (LD_LRU_in) last_lru_val = lru_in_value;
            if (pmem_write) pw_cycles++;
            if (pmem_read && pmem_write) both_hi++;
        end
    end

    // ---------------- transaction model ----------------
    bit [23:0] m_tag   [8][2];
    bit        m_valid [8][2];
    bit        m_dirty [8][2];
    bit        m_lru   [8];
    int exp_hit = 0, exp_miss = 0, exp_wb = 0;
    bit commit_pending = 0;
    int last_start = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int sat15(int v);
        return (v > 15) ? 15 : v;
    endfunction

    task automatic check_counters();
        check("hit_cnt",    hit_cnt,    exp_hit);
        check("miss_cnt",   miss_cnt,   exp_miss);
        check("wb_cnt",     wb_cnt,     exp_wb);
        check("s_hit_cnt",  {28'h0, s_hit_cnt},  sat15(exp_hit));
        check("s_miss_cnt", {28'h0, s_miss_cnt}, sat15(exp_miss));
    endtask

    // One CPU request: predict the full per-cycle output timeline, then drive it.
    task automatic do_req(input logic [31:0] a, input bit wr, input bit both,
                          input int lwb, input int lf);
        int          set;
        logic [23:0] t;
        bit          hit, w, v;
        logic [15:0] tl[$];
        bit          pr[$];
        set = int'(a[7:5]);
        t   = a[31:8];
        hit = 0;
        w   = 0;
        for (int i = 0; i < 2; i++)
            if (m_valid[set][i] && m_tag[set][i] == t) begin hit = 1; w = i[0]; end
        if (commit_pending) begin tl.push_back(16'h0); pr.push_back(0); end
        tl.push_back(16'h0); pr.push_back(0);
        if (!hit) begin
            v = m_lru[set];
            exp_miss++;
            tl.push_back(16'h0); pr.push_back(0);
            if (m_valid[set][v] && m_dirty[set][v]) begin
                exp_wb++;
                for (int i = 0; i < lwb; i++) begin tl.push_back(E_WB); pr.push_back(i == lwb - 1); end
            end
            for (int i = 0; i < lf; i++) begin
                tl.push_back(i == lf - 1 ? mk_fw(v) : E_FA);
                pr.push_back(i == lf - 1);
            end
            tl.push_back(16'h0); pr.push_back(0);
            m_tag[set][v]   = t;
            m_valid[set][v] = 1;
            m_dirty[set][v] = 0;
            w = v;
        end
        tl.push_back(mk_hit(w, wr)); pr.push_back(0);
        exp_hit++;
        m_lru[set] = !w;
        if (wr) m_dirty[set][w] = 1;

        addr       = a;
        mem_write  = wr;
        mem_read   = !wr || both;
        last_start = cyc;
        foreach (tl[i]) exp_q.push_back(tl[i]);
        for (int i = 0; i < tl.size(); i++) begin
            pmem_resp = pr[i];
            tick();
        end
        pmem_resp      = 0;
        mem_read       = 0;
        mem_write      = 0;
        commit_pending = wr;
        check_counters();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 0; mem_read = 0; mem_write = 0; pmem_resp = 0; addr = 32'h0;
        tick(); tick();
        check("reset_outputs", {mem_resp, pmem_read, pmem_write, W_CACHE_STATUS, LD_TAG,
              LD_VALID, LD_DIRTY_in, valid_in, dirty_in_value, lru_in_value, LD_LRU_in}, 0);
        check("reset_hit_cnt", hit_cnt, 0);
        rst = 1;
        chk_en = 1;
        tick();

        // Reset lands in the middle of a fill to set 5.
        addr = 32'h0000_00A0;
        mem_read = 1;
        exp_q.push_back(16'h0); exp_q.push_back(16'h0);
        exp_q.push_back(E_FA);  exp_q.push_back(E_FA);
        tick(); tick(); tick();
        #1;
        check("midfill_pmem_read", pmem_read, 1);
        check("midfill_miss_cnt", miss_cnt, 1);
        chk_en = 0;
        rst = 0;
        #1;
        check("rst_pmem_read", pmem_read, 0);
        check("rst_status", W_CACHE_STATUS, 0);
        check("rst_miss_cnt", miss_cnt, 0);
        exp_q.delete();
        mem_read = 0;
        tick(); tick();
        rst = 1;
        chk_en = 1;
        exp_hit = 0; exp_miss = 0; exp_wb = 0;
        commit_pending = 0;
        tick();

        // Clean miss to empty set 3, memory answers on the sixth FILL cycle.
        do_req(32'h0000_0060, 0, 0, 0, 6);
        check("fill_resp_cycle", resp_at - last_start, 9);
        check("fill_ld_tag", last_ld_tag, 2'b01);
        check("fill_miss_cnt", miss_cnt, 1);
        check("fill_hit_cnt", hit_cnt, 1);

        do_req(32'h0000_0060, 0, 0, 0, 1);
        check("rehit_resp_cycle", resp_at - last_start, 1);
        check("rehit_lru_val", last_lru_val, 1);
        check("rehit_hit_cnt", hit_cnt, 2);

        // Write hit followed immediately by a read: COMMIT delays the read one cycle.
        do_req(32'h0000_0060, 1, 0, 0, 1);
        do_req(32'h0000_0060, 0, 0, 0, 1);
        check("post_commit_resp_cycle", resp_at - last_start, 2);
        check("dirty_landed", e_dirty[3][0], 1);

        // Stray memory response while idle is ignored.
        pmem_resp = 1;
        tick();
        pmem_resp = 0;

        do_req(32'h0000_0060, 1, 1, 0, 1);

        // Set 2: fill both ways, dirty the LRU way, then evict it with a third tag.
        do_req(32'h0000_1040, 0, 0, 0, 3);
        do_req(32'h0000_2040, 0, 0, 0, 2);
        do_req(32'h0000_1040, 1, 0, 0, 1);
        do_req(32'h0000_2040, 0, 0, 0, 1);
        pw_cycles = 0;
        do_req(32'h0000_3040, 0, 0, 4, 3);
        check("wb_cnt_one", wb_cnt, 1);
        check("wb_cycles", pw_cycles, 4);
        check("strobes_exclusive", both_hi, 0);

        for (int i = 0; i < 20; i++) do_req(32'h0000_0060, 0, 0, 0, 1);
        check("sat_hit_cnt", {28'h0, s_hit_cnt}, 15);

        tick(); tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
